mem_port_arbiter: RTL and testbench

Shares the single-port data RAM between three requesters: the control path's load/store path (requester 0), instruction fetch (requester 1) and the VGA framebuffer reader (requester 2). The block sits between the control/data paths and the RAM primitive. It serialises accesses, registers the RAM-side address, data and enables, waits out the RAM read latency and returns a one-cycle acknowledge to the requester it served. The control path's wait_read/wait_write states stall on this acknowledge.

---
 rtl/mem_port_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Purpose: serialises three requesters (load/store, fetch, VGA) onto one single-port RAM.
// Latency: write acks 2 cycles after the request is seen in IDLE, read acks 2+RD_LAT cycles after.
// Backpressure: requesters hold req until ack; others wait in IDLE. Optional macro MEM_PORT_ARBITER_RR_EN selects round-robin.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1   // legal range 1..4; the wait counter is 3 bits wide
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            req,
    input  logic [2:0]            we,
    input  logic [3*ADDR_W-1:0]   addr,
    input  logic [3*DATA_W-1:0]   wdata,
    output logic [2:0]            ack,
    output logic [2:0]            gnt,
    output logic [DATA_W-1:0]     rdata,
    output logic                  busy,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [2:0]          gnt_q, gnt_d;
    logic [2:0]          ack_q, ack_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    // Arbitration result for the current IDLE cycle
    logic                win_vld;
    logic [1:0]          win_idx;

`ifdef MEM_PORT_ARBITER_RR_EN
    logic [1:0]          ptr_q, ptr_d;
    logic [2:0]          rr_sum;
    logic [1:0]          rr_cand;

    // Round-robin pick: walk lowest priority first so the highest-priority hit is written last
    always_comb begin
        win_vld = |req;
        win_idx = 2'd0;
        rr_sum  = 3'd0;
        rr_cand = 2'd0;
        for (int k = 2; k >= 0; k--) begin
            rr_sum = {1'b0, ptr_q} + 3'(k);
            if (rr_sum >= 3'd3) begin
                rr_sum = rr_sum - 3'd3;
            end
            rr_cand = rr_sum[1:0];
            if (req[rr_cand]) begin
                win_idx = rr_cand;
            end
        end
    end

    // Pointer moves past the winner only when a grant is actually issued
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && win_vld) begin
            ptr_d = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority pick: requester 0 beats 1 beats 2
    always_comb begin
        win_vld = |req;
        win_idx = 2'd0;
        if (req[0]) begin
            win_idx = 2'd0;
        end else if (req[1]) begin
            win_idx = 2'd1;
        end else if (req[2]) begin
            win_idx = 2'd2;
        end
    end
`endif

    // Next-state and registered-output logic for the access sequencer
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_d       = gnt_q;
        ack_d       = 3'b000;
        rdata_d     = rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d     = ISSUE;
                    gnt_d       = 3'b001 << win_idx;
                    mem_en_d    = 1'b1;
                    mem_we_d    = we[win_idx];
                    mem_addr_d  = addr[win_idx*ADDR_W +: ADDR_W];
                    mem_wdata_d = wdata[win_idx*DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                // mem_we_q still carries the latched direction during ISSUE
                if (mem_we_q) begin
                    state_d = DONE;
                    ack_d   = gnt_q;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 3'(RD_LAT);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                    ack_d   = gnt_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 3'b000;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transaction without an ack
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            gnt_q       <= 3'b000;
            ack_q       <= 3'b000;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            busy_q      <= busy_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign ack       = ack_q;
    assign gnt       = gnt_q;
    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;
    localparam int RD_LAT = 2;

    logic                 clock;
    logic                 reset;
    logic [2:0]           req;
    logic [2:0]           we;
    logic [3*ADDR_W-1:0]  addr;
    logic [3*DATA_W-1:0]  wdata;
    logic [2:0]           ack;
    logic [2:0]           gnt;
    logic [DATA_W-1:0]    rdata;
    logic                 busy;
    logic                 mem_en;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_wdata;
    logic [DATA_W-1:0]    mem_rdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .ack       (ack),
        .gnt       (gnt),
        .rdata     (rdata),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Small RAM with RD_LAT-cycle read pipeline; preloaded while reset is high
    logic [DATA_W-1:0] ram [0:255];
    logic [DATA_W-1:0] pipe [0:RD_LAT-1];

    always @(posedge clock) begin
        if (reset) begin
            ram[8'h10] <= 16'h1234;
        end else if (mem_en && mem_we) begin
            ram[mem_addr[7:0]] <= mem_wdata;
        end
        if (mem_en && !mem_we) begin
            pipe[0] <= ram[mem_addr[7:0]];
        end
        for (int k = 1; k < RD_LAT; k++) begin
            pipe[k] <= pipe[k-1];
        end
    end
    assign mem_rdata = pipe[RD_LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) until an ISSUE cycle (want_ack=0) or an ack cycle (want_ack=1)
    task automatic wait_for(input bit want_ack, input string tag);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clock);
            if (want_ack ? (ack != 3'b000) : mem_en) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, {31'd0, found}, 32'd1);
    endtask

    task automatic set_port(input int i, input logic [15:0] a, input logic [15:0] d);
        addr[i*ADDR_W +: ADDR_W]  = a;
        wdata[i*DATA_W +: DATA_W] = d;
    endtask

    logic [2:0]  exp_g [0:3];
    logic [15:0] exp_d [0:3];
    bit          no_ack;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, required finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef MEM_PORT_ARBITER_RR_EN
        exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
        exp_d[0] = 16'hBEEF; exp_d[1] = 16'h1234; exp_d[2] = 16'h5555; exp_d[3] = 16'hBEEF;
`else
        exp_g[0] = 3'b001; exp_g[1] = 3'b001; exp_g[2] = 3'b001; exp_g[3] = 3'b001;
        exp_d[0] = 16'hBEEF; exp_d[1] = 16'hBEEF; exp_d[2] = 16'hBEEF; exp_d[3] = 16'hBEEF;
`endif
        reset = 1'b1;
        req   = 3'b000;
        we    = 3'b000;
        addr  = '0;
        wdata = '0;

        // Reset values
        @(negedge clock);
        chk("rst_ack",       {29'd0, ack}, 32'd0);
        chk("rst_gnt",       {29'd0, gnt}, 32'd0);
        chk("rst_en_we_busy",{29'd0, mem_en, mem_we, busy}, 32'd0);
        chk("rst_rdata",     {16'd0, rdata}, 32'd0);
        chk("rst_mem_addr",  {16'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        reset = 1'b0;

        // Idle for 10 cycles
        repeat (10) begin
            @(negedge clock);
            chk("idle_en_busy_gnt", {27'd0, mem_en, busy, gnt}, 32'd0);
        end

        // Single write from requester 0
        set_port(0, 16'h0040, 16'hBEEF);
        req = 3'b001; we = 3'b001;
        @(negedge clock);
        chk("wr_c1_en_we",   {30'd0, mem_en, mem_we}, 32'd3);
        chk("wr_c1_addr",    {16'd0, mem_addr}, 32'h0040);
        chk("wr_c1_wdata",   {16'd0, mem_wdata}, 32'hBEEF);
        chk("wr_c1_gnt",     {29'd0, gnt}, 32'b001);
        chk("wr_c1_ack",     {29'd0, ack}, 32'd0);
        chk("wr_c1_busy",    {31'd0, busy}, 32'd1);
        req = 3'b000;
        @(negedge clock);
        chk("wr_c2_ack",     {29'd0, ack}, 32'b001);
        chk("wr_c2_en",      {31'd0, mem_en}, 32'd0);
        @(negedge clock);
        chk("wr_c3_ack_gnt_busy", {25'd0, ack, gnt, busy}, 32'd0);

        // Single read from requester 1 (RD_LAT = 2 -> ack at cycle 4)
        set_port(1, 16'h0010, 16'h0000);
        req = 3'b010; we = 3'b000;
        @(negedge clock);
        chk("rd_c1_en_we",   {30'd0, mem_en, mem_we}, 32'd2);
        chk("rd_c1_addr",    {16'd0, mem_addr}, 32'h0010);
        chk("rd_c1_gnt",     {29'd0, gnt}, 32'b010);
        req = 3'b000;
        @(negedge clock);
        chk("rd_c2_en_we_ack", {27'd0, mem_en, mem_we, ack}, 32'd0);
        @(negedge clock);
        chk("rd_c3_ack",     {29'd0, ack}, 32'd0);
        @(negedge clock);
        chk("rd_c4_ack",     {29'd0, ack}, 32'b010);
        chk("rd_c4_rdata",   {16'd0, rdata}, 32'h1234);
        @(negedge clock);
        chk("rd_c5_ack_busy", {28'd0, ack, busy}, 32'd0);

        // Write from requester 2 must not touch rdata
        set_port(2, 16'h0020, 16'h5555);
        req = 3'b100; we = 3'b100;
        @(negedge clock);
        chk("wr2_c1_gnt",    {29'd0, gnt}, 32'b100);
        chk("wr2_c1_addr",   {16'd0, mem_addr}, 32'h0020);
        req = 3'b000;
        @(negedge clock);
        chk("wr2_c2_ack",    {29'd0, ack}, 32'b100);
        @(negedge clock);
        chk("wr2_rdata_kept", {16'd0, rdata}, 32'h1234);
        chk("wr2_ram",       {16'd0, ram[8'h20]}, 32'h5555);

        // Requester 2 reads and drops req during ISSUE
        req = 3'b100; we = 3'b000;
        @(negedge clock);
        chk("cm_c1_en_gnt",  {28'd0, mem_en, gnt}, 32'b1100);
        req = 3'b000;
        @(negedge clock);
        chk("cm_c2_ack",     {29'd0, ack}, 32'd0);
        @(negedge clock);
        chk("cm_c3_ack",     {29'd0, ack}, 32'd0);
        @(negedge clock);
        chk("cm_c4_ack",     {29'd0, ack}, 32'b100);
        chk("cm_c4_rdata",   {16'd0, rdata}, 32'h5555);
        @(negedge clock);
        chk("cm_c5_idle",    {25'd0, ack, gnt, busy}, 32'd0);

        // Contention: all three read continuously
        set_port(0, 16'h0040, 16'h0000);
        set_port(1, 16'h0010, 16'h0000);
        set_port(2, 16'h0020, 16'h0000);
        req = 3'b111; we = 3'b000;
        for (int t = 0; t < 4; t++) begin
            wait_for(1'b0, "ct_issue_timeout");
            chk("ct_gnt",   {29'd0, gnt}, {29'd0, exp_g[t]});
            wait_for(1'b1, "ct_ack_timeout");
            chk("ct_ack",   {29'd0, ack}, {29'd0, exp_g[t]});
            chk("ct_rdata", {16'd0, rdata}, {16'd0, exp_d[t]});
        end
        req = 3'b000;
        @(negedge clock);
        @(negedge clock);
        chk("ct_after_busy", {31'd0, busy}, 32'd0);

        // Reset during the WAIT phase of a read
        req = 3'b010; we = 3'b000;
        @(negedge clock);
        chk("rr_c1_en",      {31'd0, mem_en}, 32'd1);
        req = 3'b000;
        @(negedge clock);
        chk("rr_c2_busy",    {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("rr_async_en_we", {30'd0, mem_en, mem_we}, 32'd0);
        chk("rr_async_gnt",  {29'd0, gnt}, 32'd0);
        chk("rr_async_ack",  {29'd0, ack}, 32'd0);
        chk("rr_async_busy", {31'd0, busy}, 32'd0);
        chk("rr_async_rdata", {16'd0, rdata}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        no_ack = 1'b1;
        repeat (6) begin
            @(negedge clock);
            if (ack != 3'b000) no_ack = 1'b0;
        end
        chk("rr_no_ack",     {31'd0, no_ack}, 32'd1);

        // Fresh request after reset: pointer at 0 so requester 0 beats 2
        req = 3'b101; we = 3'b000;
        @(negedge clock);
        chk("post_c1_gnt",   {29'd0, gnt}, 32'b001);
        req = 3'b000;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        chk("post_c4_ack",   {29'd0, ack}, 32'b001);
        chk("post_c4_rdata", {16'd0, rdata}, 32'hBEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
